// File: rtl/armleocpu_tlb_sa.sv
// armleocpu_tlb_sa
// Set-associative TLB: 2^ENTRIES_W sets x 2^WAYS_W ways, registered lookup,
// single-cycle fill, and a flush-all that sweeps one set per cycle.
//
// Optional feature: define ARMLEOCPU_TLB_SA_ASID_EN to add the asid input.
// Each entry then stores an ASID, and a hit needs the stored ASID to equal
// asid or the stored G bit (bit 5) to be set.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           translation enable (0 = identity bypass)
//   resolve          lookup request for virtual_address
//   write            fill request for virtual_address
//   invalidate       flush-all request
//   virtual_address  VPN; set index [ENTRIES_W-1:0], tag [19:ENTRIES_W]
//   accesstag_w      access bits to store (bit0 = V)
//   phys_w           PPN to store
//   done             lookup result valid (one-cycle pulse)
//   miss             lookup missed, qualified by done
//   accesstag_r      access bits of the hit entry
//   phys_r           PPN of the hit entry
//   busy             flush in progress; all requests are ignored
//
// state   | meaning
// S_IDLE  | accepting requests (priority invalidate > write > resolve)
// S_FLUSH | clearing one set per cycle; entered from reset and on invalidate
module armleocpu_tlb_sa #(
  parameter int ENTRIES_W = 4,
  parameter int WAYS_W    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ARMLEOCPU_TLB_SA_ASID_EN
  input  logic [8:0]  asid,
`endif
  input  logic        enable,
  input  logic        resolve,
  input  logic        write,
  input  logic        invalidate,
  input  logic [19:0] virtual_address,
  input  logic [7:0]  accesstag_w,
  input  logic [21:0] phys_w,
  output logic        done,
  output logic        miss,
  output logic [7:0]  accesstag_r,
  output logic [21:0] phys_r,
  output logic        busy
);

  localparam int SETS = 1 << ENTRIES_W;
  localparam int WAYS = 1 << WAYS_W;
  localparam int TW   = 20 - ENTRIES_W;
  localparam int VW   = (WAYS_W == 0) ? 1 : WAYS_W;

  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ENTRIES_W-1:0] r_flush_set;
  logic [VW-1:0]        r_victim [SETS];

  logic [TW-1:0]        r_tag  [SETS][WAYS];
  logic [7:0]           r_atag [SETS][WAYS];
  logic [21:0]          r_phys [SETS][WAYS];
`ifdef ARMLEOCPU_TLB_SA_ASID_EN
  logic [8:0]           r_asid [SETS][WAYS];
`endif

  logic                 r_done;
  logic                 r_miss;
  logic [7:0]           r_atag_r;
  logic [21:0]          r_phys_r;

  logic [ENTRIES_W-1:0] w_idx;
  logic [TW-1:0]        w_vtag;
  logic                 w_busy;
  logic                 w_do_write;
  logic                 w_do_resolve;
  logic                 w_hit;
  logic [VW-1:0]        w_hit_way;
  logic                 w_free;
  logic [VW-1:0]        w_free_way;
  logic                 w_use_victim;
  logic [VW-1:0]        w_wr_way;

  assign w_idx        = virtual_address[ENTRIES_W-1:0];
  assign w_vtag       = virtual_address[19:ENTRIES_W];
  assign w_busy       = (r_state == S_FLUSH);
  assign w_do_write   = !w_busy && !invalidate && write;
  assign w_do_resolve = !w_busy && !invalidate && !write && resolve;

  // Hit search and lowest free way, both from the current array contents, so
  // a fill at edge N is already visible to a lookup sampled at edge N+1.
  always_comb begin
    logic l_match;
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      l_match = r_atag[w_idx][w][0] && (r_tag[w_idx][w] == w_vtag);
`ifdef ARMLEOCPU_TLB_SA_ASID_EN
      l_match = l_match && ((r_asid[w_idx][w] == asid) || r_atag[w_idx][w][5]);
`endif
      if (!w_hit && l_match) begin
        w_hit     = 1'b1;
        w_hit_way = VW'(w);
      end
      if (!w_free && !r_atag[w_idx][w][0]) begin
        w_free     = 1'b1;
        w_free_way = VW'(w);
      end
    end
  end

  assign w_use_victim = !w_hit && !w_free;
  assign w_wr_way     = w_hit ? w_hit_way : (w_free ? w_free_way : r_victim[w_idx]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (invalidate) w_state_nxt = S_FLUSH;
      S_FLUSH: if (r_flush_set == ENTRIES_W'(SETS - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_FLUSH;
    endcase
  end

  // Entry storage has no reset: reset parks the FSM in S_FLUSH, which clears
  // every V bit before any request is accepted.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      for (int w = 0; w < WAYS; w++) r_atag[r_flush_set][w] <= 8'h00;
    end else if (w_do_write) begin
      r_tag[w_idx][w_wr_way]  <= w_vtag;
      r_atag[w_idx][w_wr_way] <= accesstag_w;
      r_phys[w_idx][w_wr_way] <= phys_w;
`ifdef ARMLEOCPU_TLB_SA_ASID_EN
      r_asid[w_idx][w_wr_way] <= asid;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FLUSH;
      r_flush_set <= '0;
      for (int s = 0; s < SETS; s++) r_victim[s] <= '0;
      r_done      <= 1'b0;
      r_miss      <= 1'b0;
      r_atag_r    <= 8'h00;
      r_phys_r    <= 22'h0;
    end else begin
      r_state <= w_state_nxt;
      // Wraps to 0 on the last flushed set, ready for the next flush.
      if (w_busy) r_flush_set <= r_flush_set + 1'b1;
      if (w_do_write && w_use_victim)
        r_victim[w_idx] <= (WAYS == 1) ? '0 : r_victim[w_idx] + 1'b1;
      r_done <= w_do_resolve;
      r_miss <= w_do_resolve && enable && !w_hit;
      if (w_do_resolve) begin
        if (!enable) begin
          r_phys_r <= {2'b00, virtual_address};
          r_atag_r <= 8'b1100_1111;
        end else if (w_hit) begin
          r_phys_r <= r_phys[w_idx][w_hit_way];
          r_atag_r <= r_atag[w_idx][w_hit_way];
        end
      end
    end
  end

  assign done        = r_done;
  assign miss        = r_miss;
  assign accesstag_r = r_atag_r;
  assign phys_r      = r_phys_r;
  assign busy        = w_busy;

endmodule
